// File: rtl/task_scheduler_if.sv
// Op-bus bundle between the task slots / host and the scheduler.
// The scheduler connects through the slave modport.
interface task_scheduler_if #(
    parameter int N_TASKS = 8
);
    logic [8*N_TASKS-1:0] task_words;
    logic [15:0]          host_op;
    logic                 host_valid;
    logic                 host_ready;
    logic [15:0]          out_op;
    logic [3:0]           cur_task;
    logic                 busy;
    logic                 slice_done;

    modport master (
        output task_words, host_op, host_valid,
        input  host_ready, out_op, cur_task, busy, slice_done
    );

    modport slave (
        input  task_words, host_op, host_valid,
        output host_ready, out_op, cur_task, busy, slice_done
    );
endinterface

// File: rtl/task_scheduler.sv
// Priority / round-robin time-slice scheduler with host command arbitration.
// Optional macro TASK_SCHED_PREEMPT_EN: a strictly higher-priority slot ends the slice early.
module task_scheduler #(
    parameter int N_TASKS      = 8,
    parameter int SLICE_CYCLES = 10000,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    task_scheduler_if.slave  bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SCAN   = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] RUN    = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;
    localparam logic [2:0] HOST   = 3'd5;

    localparam logic [3:0]       OPC_EXEC = 4'b0111;
    localparam logic [3:0]       OPC_FIN  = 4'b1111;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICE_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       rr_q, rr_d;
    logic [3:0]       win_idx_q, win_idx_d;
    logic [3:0]       win_id_q, win_id_d;
`ifdef TASK_SCHED_PREEMPT_EN
    logic [3:0]       win_p_q, win_p_d;
`endif
    logic [15:0]      op_q, op_d;
    logic [3:0]       cur_q, cur_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [3:0] prty [N_TASKS];
    logic [3:0] ids  [N_TASKS];
    logic [3:0] best_p, best_idx, best_id;
    logic       win_zero, preempt;

    // Split each slot word into id and priority nibbles
    always_comb begin
        for (int i = 0; i < N_TASKS; i++) begin
            prty[i] = bus.task_words[8*i +: 4];
            ids[i]  = bus.task_words[8*i+4 +: 4];
        end
    end

    // Highest priority wins; ties go to the first slot after rr_q (wrapping)
    always_comb begin
        best_p   = 4'h0;
        best_idx = 4'h0;
        best_id  = 4'h0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N_TASKS; i++) begin
                if (((p == 0) ? (4'(i) > rr_q) : (4'(i) <= rr_q))
                    && prty[i] > best_p) begin
                    best_p   = prty[i];
                    best_idx = 4'(i);
                    best_id  = ids[i];
                end
            end
        end
    end

    // Watch the running slot for withdrawal and for higher-priority rivals
    always_comb begin
        win_zero = 1'b0;
        preempt  = 1'b0;
        for (int i = 0; i < N_TASKS; i++) begin
            if (4'(i) == win_idx_q) begin
                if (bus.task_words[8*i +: 8] == 8'h00) win_zero = 1'b1;
            end
`ifdef TASK_SCHED_PREEMPT_EN
            else if (prty[i] > win_p_q) begin
                preempt = 1'b1;
            end
`endif
        end
    end

    // Next state, slice counter, winner latch and registered op word
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        win_idx_d = win_idx_q;
        win_id_d  = win_id_q;
`ifdef TASK_SCHED_PREEMPT_EN
        win_p_d   = win_p_q;
`endif
        op_d      = 16'h0000;
        unique case (state_q)
            IDLE: begin
                if (bus.host_valid) begin
                    state_d = HOST;
                    op_d    = bus.host_op;
                end else if (best_p != 4'h0) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (best_p != 4'h0) begin
                    state_d   = EXEC;
                    win_idx_d = best_idx;
                    win_id_d  = best_id;
`ifdef TASK_SCHED_PREEMPT_EN
                    win_p_d   = best_p;
`endif
                    op_d      = {4'h0, best_id, OPC_EXEC, 4'h0};
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                state_d = RUN;
                cnt_d   = '0;
                rr_d    = win_idx_q;
            end
            RUN: begin
                if (win_zero) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST || preempt) begin
                    state_d = FINISH;
                    cnt_d   = '0;
                    op_d    = {4'h0, win_id_q, OPC_FIN, 4'h0};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FINISH:  state_d = IDLE;
            HOST:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs follow the state being entered
    always_comb begin
        busy_d = (state_d == EXEC) || (state_d == RUN) || (state_d == FINISH);
        cur_d  = busy_d ? win_id_d : 4'h0;
        done_d = (state_d == FINISH);
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_q      <= 4'h0;
            win_idx_q <= 4'h0;
            win_id_q  <= 4'h0;
`ifdef TASK_SCHED_PREEMPT_EN
            win_p_q   <= 4'h0;
`endif
            op_q      <= 16'h0000;
            cur_q     <= 4'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            win_idx_q <= win_idx_d;
            win_id_q  <= win_id_d;
`ifdef TASK_SCHED_PREEMPT_EN
            win_p_q   <= win_p_d;
`endif
            op_q      <= op_d;
            cur_q     <= cur_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.host_ready = (state_q == IDLE) && !RST;
    assign bus.out_op     = op_q;
    assign bus.cur_task   = cur_q;
    assign bus.busy       = busy_q;
    assign bus.slice_done = done_q;
endmodule
